seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Reader side of the multiplexed seven-segment display interface: samples the active-low anode select and segment bus, waits for stable values, and decodes each digit's 8-bit segment pattern back to its 4-bit symbol code.
- Stores one code per digit position and signals per-digit updates and completed frames.
- Used for display loopback self-test and for monitoring the display bus in the lab top level.

Parameters:
- DIGITS, 8, number of multiplexed digit positions; legal range 2..16.
- STABLE_CYCLES, 4, consecutive cycles the synchronised an/seg pair must hold before capture; minimum 1.
- IDXW, $clog2(DIGITS), localparam, width of the digit index.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- an  input  DIGITS  anode select, active low; exactly one bit low selects that digit.
- seg  input  8  segment bus, active low; bit7..bit1 = a..g, bit0 = dp.
- digits  output  DIGITS*4  decoded codes; digit i occupies bits [4i+3:4i].
- digit_err  output  DIGITS  bit i set when the last capture of digit i was an undecodable pattern.
- upd  output  1  one-cycle pulse per capture.
- upd_idx  output  IDXW  digit index of the current capture; valid while upd is high.
- upd_code  output  4  code written by the current capture; valid while upd is high.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Reset values: digits all 4'hF; digit_err 0; upd 0; upd_idx 0; upd_code 0; frame_done 0. Internally, sync flops are set to all ones (idle bus), the counter is cleared, the seen mask is cleared, and the FSM is in IDLE.
- Input sync: an and seg each pass through a 2-flop synchroniser. All subsequent logic uses the synchronised values.
- Decode table (seg to code):
  - 03 → 0, 9F → 1, 25 → 2, 0D → 3, 99 → 4, 49 → 5, C1 → 6, 1F → 7, 01 → 8, 19 → 9.
  - FE → 10 (dot), 81 → 11 (hash), FF → 15 (blank).
  - Any other value → code 4'hE with err = 1. For all table hits, err = 0.
- FSM, three states:
  - IDLE: synchronised an is not one-hot-low (all high, or more than one low). Counter held at 0. No capture.
  - SETTLE: an is one-hot-low. Counter increments each cycle the synchronised {an,seg} equals its previous-cycle value. Any change reloads the counter to 0 and stays in SETTLE; if an becomes non-one-hot, go to IDLE. When the counter reaches STABLE_CYCLES-1 with inputs still unchanged, capture and go to CAPTURED.
  - CAPTURED: remains while {an,seg} is unchanged; no further captures. Any change goes to SETTLE with counter 0, or to IDLE if an is not one-hot.
- Capture (registered, visible the next cycle):
  - digits[idx] ← code and digit_err[idx] ← err.
  - upd = 1, upd_idx = idx, upd_code = code.
  - seen[idx] ← 1.
- Latency: with raw an/seg stable from cycle t, upd is high in cycle t+2+STABLE_CYCLES. With STABLE_CYCLES = 1, capture occurs on the first synchronised cycle of a new value.
- Frame:
  - If a capture makes the seen mask all ones, frame_done pulses in the same cycle as that upd, and the seen mask clears in that cycle.
  - Recapturing an already-seen digit only updates its storage.
- Glitches: any value held fewer than STABLE_CYCLES synchronised cycles is never captured, and stored data is untouched.
- Reset mid-operation: asserting rst at any time immediately returns all state to the reset values. A partial settle or partial frame is discarded.
- digits and digit_err change only on capture or reset.

Test Plan:
- Reset: rst high, then low → digits = 32'hFFFF_FFFF, digit_err = 0, no upd or frame_done pulses while an = 8'hFF.
- Single capture: an = 8'hFB, seg = 8'h0D held for 10 cycles (STABLE_CYCLES = 4) → exactly one upd, 6 cycles after the change, with upd_idx = 2, upd_code = 3; digits[11:8] = 3.
- Glitch: hold an = 8'hFE, seg = 8'h03 for 3 cycles, then seg = 8'h9F held → no capture of 0; single upd with upd_idx = 0, upd_code = 1.
- Invalid and special patterns: seg = 8'hAA on digit 5 → upd_code = 4'hE, digit_err[5] = 1; seg = 8'hFE on digit 5 → code 10, digit_err[5] clears.
- Full scan: cycle an through all 8 digits with patterns for 0..7, each held 8 cycles → 8 upd pulses, frame_done coincident with the 8th only. Repeat the scan → a second frame_done.
- Non-one-hot and reset: an = 8'hFC, seg = 8'h01 held → no upd. A valid settle interrupted by rst at count 2 → no upd; state returns to reset values.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Reader side of a multiplexed seven-segment display bus. The active-low anode
// select and segment bus are synchronised, checked for a stable one-hot-low
// anode, and once a value has held for STABLE_CYCLES synchronised cycles the
// segment pattern is decoded back to its 4-bit symbol code and stored in the
// slot of the selected digit.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   an          anode select, active low (one low bit selects a digit)
//   seg         segment bus, active low; bit7..bit1 = a..g, bit0 = dp
//   digits      decoded codes, digit i in bits [4i+3:4i]
//   digit_err   bit i set when the last capture of digit i was undecodable
//   upd         one-cycle pulse per capture
//   upd_idx     digit index of the current capture (valid with upd)
//   upd_code    code written by the current capture (valid with upd)
//   frame_done  one-cycle pulse when every digit was captured since last pulse
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter  int DIGITS        = 8,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDXW          = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an,
    input  logic [7:0]            seg,
    output logic [DIGITS*4-1:0]   digits,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  upd,
    output logic [IDXW-1:0]       upd_idx,
    output logic [3:0]            upd_code,
    output logic                  frame_done
);

    // The counter only needs to reach STABLE_CYCLES-1; it saturates there.
    localparam int              CNTW    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPT
    } state_t;

    // Segment pattern to {err, code}. Unknown patterns report code E with err.
    function automatic logic [4:0] f_decode(input logic [7:0] s);
        logic [4:0] r;
        case (s)
            8'h03:   r = {1'b0, 4'h0};
            8'h9F:   r = {1'b0, 4'h1};
            8'h25:   r = {1'b0, 4'h2};
            8'h0D:   r = {1'b0, 4'h3};
            8'h99:   r = {1'b0, 4'h4};
            8'h49:   r = {1'b0, 4'h5};
            8'hC1:   r = {1'b0, 4'h6};
            8'h1F:   r = {1'b0, 4'h7};
            8'h01:   r = {1'b0, 4'h8};
            8'h19:   r = {1'b0, 4'h9};
            8'hFE:   r = {1'b0, 4'hA};  // dot only
            8'h81:   r = {1'b0, 4'hB};  // hash
            8'hFF:   r = {1'b0, 4'hF};  // blank
            default: r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- sync
    logic [DIGITS-1:0] r_an_s1, r_an_s2, r_an_p;
    logic [7:0]        r_seg_s1, r_seg_s2, r_seg_p;

    // Sync flops and the previous-cycle copy all reset to the idle bus value,
    // so a digit already selected when reset drops is seen as a fresh change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_s1  <= '1;
            r_an_s2  <= '1;
            r_an_p   <= '1;
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_seg_p  <= '1;
        end else begin
            r_an_s1  <= an;
            r_an_s2  <= r_an_s1;
            r_an_p   <= r_an_s2;
            r_seg_s1 <= seg;
            r_seg_s2 <= r_seg_s1;
            r_seg_p  <= r_seg_s2;
        end
    end

    // ------------------------------------------------------- anode decode
    logic [DIGITS-1:0] w_an_inv;
    logic              w_onehot;
    logic [IDXW-1:0]   w_idx;

    assign w_an_inv = ~r_an_s2;
    assign w_onehot = ($countones(w_an_inv) == 1);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_an_inv[i]) w_idx = IDXW'(i);
        end
    end

    // ------------------------------------------------------ settle / FSM
    state_t          r_state, w_state_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt, w_run;
    logic            w_changed;
    logic            w_capture;
    logic [4:0]      w_dec;

    assign w_changed = ({r_an_s2, r_seg_s2} != {r_an_p, r_seg_p});
    assign w_dec     = f_decode(r_seg_s2);

    // w_run is the number of cycles the current synchronised value has been
    // held, minus one: 0 on the cycle of a change. A capture fires on the
    // cycle it reaches STABLE_CYCLES-1, and only once per held value.
    always_comb begin
        w_run = '0;
        if (!w_changed) begin
            w_run = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNTW'(1);
        end
    end

    assign w_capture = w_onehot && (w_run == CNT_MAX) &&
                       (w_changed || (r_state != S_CAPT));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_run;
        case (r_state)
            S_IDLE: begin
                if (!w_onehot) begin
                    w_cnt_nxt = '0;
                end else if (w_capture) begin
                    w_state_nxt = S_CAPT;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!w_onehot) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_capture) begin
                    w_state_nxt = S_CAPT;
                end
            end
            S_CAPT: begin
                if (!w_onehot) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_changed) begin
                    // With STABLE_CYCLES = 1 the new value captures at once.
                    w_state_nxt = w_capture ? S_CAPT : S_SETTLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------- storage and frame
    logic [DIGITS-1:0][3:0] r_digits;
    logic [DIGITS-1:0]      r_err;
    logic [DIGITS-1:0]      r_seen;
    logic [DIGITS-1:0]      w_seen_set;
    logic                   w_frame;
    logic                   r_upd, r_frame;
    logic [IDXW-1:0]        r_upd_idx;
    logic [3:0]             r_upd_code;

    assign w_seen_set = r_seen | (DIGITS'(1) << w_idx);
    assign w_frame    = &w_seen_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits   <= {DIGITS{4'hF}};
            r_err      <= '0;
            r_seen     <= '0;
            r_upd      <= 1'b0;
            r_upd_idx  <= '0;
            r_upd_code <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_upd   <= w_capture;
            r_frame <= w_capture && w_frame;
            if (w_capture) begin
                r_digits[w_idx] <= w_dec[3:0];
                r_err[w_idx]    <= w_dec[4];
                r_upd_idx       <= w_idx;
                r_upd_code      <= w_dec[3:0];
                // The completing capture clears the mask so the next frame
                // starts empty.
                r_seen          <= w_frame ? '0 : w_seen_set;
            end
        end
    end

    assign digits     = r_digits;
    assign digit_err  = r_err;
    assign upd        = r_upd;
    assign upd_idx    = r_upd_idx;
    assign upd_code   = r_upd_code;
    assign frame_done = r_frame;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a history-based reference model (a capture is
// expected exactly when the effective bus value has just completed its
// STABLE_CYCLES-th consecutive cycle) compared every cycle, plus directed
// literal expectations.
module tb_seg_scan_decoder;
    localparam int D  = 8;
    localparam int S  = 4;
    localparam int NH = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   an  = 8'hFF;
    logic [7:0]   seg = 8'hFF;
    logic [D*4-1:0] digits;
    logic [D-1:0] digit_err;
    logic         upd;
    logic [2:0]   upd_idx;
    logic [3:0]   upd_code;
    logic         frame_done;

    seg_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .digits(digits), .digit_err(digit_err), .upd(upd),
        .upd_idx(upd_idx), .upd_code(upd_code), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
        end
    endtask

    // -------------------------------------------------- input history
    int          cyc = 0;
    logic [15:0] raw_h [NH];
    logic        rst_h [NH];

    initial begin
        raw_h[0] = 16'hFFFF;
        rst_h[0] = 1'b1;
    end

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        raw_h[cyc+1] <= {an, seg};
        rst_h[cyc+1] <= rst;
    end

    // Value the decoder effectively sees for sample j: reset at that sample
    // or the next one wipes it back to the idle bus.
    function automatic logic [15:0] eff(input int j);
        if (j < 1) return 16'hFFFF;
        if (rst_h[j] || rst_h[j+1]) return 16'hFFFF;
        return raw_h[j];
    endfunction

    function automatic logic is_onehot_low(input logic [7:0] a);
        return $countones(~a) == 1;
    endfunction

    // Sample m is the S-th consecutive sample of a one-hot value.
    function automatic logic run_done(input int m);
        logic [15:0] v;
        if (m - S < 0) return 1'b0;
        v = eff(m);
        if (!is_onehot_low(v[15:8])) return 1'b0;
        for (int i = 1; i < S; i++) if (eff(m - i) != v) return 1'b0;
        return eff(m - S) != v;
    endfunction

    function automatic logic [4:0] tbl(input logic [7:0] s);
        case (s)
            8'h03: return 5'h00;  8'h9F: return 5'h01;  8'h25: return 5'h02;
            8'h0D: return 5'h03;  8'h99: return 5'h04;  8'h49: return 5'h05;
            8'hC1: return 5'h06;  8'h1F: return 5'h07;  8'h01: return 5'h08;
            8'h19: return 5'h09;  8'hFE: return 5'h0A;  8'h81: return 5'h0B;
            8'hFF: return 5'h0F;
            default: return 5'h1E;
        endcase
    endfunction

    // -------------------------------------------------- model + compare
    logic [3:0]   mdig [D];
    logic [D-1:0] merr  = '0;
    logic [D-1:0] mseen = '0;
    int upd_cnt = 0, frame_cnt = 0, last_upd_cyc = 0, frame_cyc = 0;
    int last_idx = 0, last_code = 0;

    initial for (int i = 0; i < D; i++) mdig[i] = 4'hF;

    always @(negedge clk) begin
        int          n, m, ix;
        logic        e_upd, e_fr;
        logic [15:0] v;
        logic [4:0]  dc;
        logic [D*4-1:0] e_dig;
        n = cyc;
        e_upd = 1'b0; e_fr = 1'b0; ix = 0; dc = '0;
        if (rst_h[n]) begin
            for (int i = 0; i < D; i++) mdig[i] = 4'hF;
            merr = '0; mseen = '0;
        end else begin
            m = n - 2;
            e_upd = run_done(m);
            if (e_upd) begin
                v = eff(m);
                for (int i = 0; i < D; i++) if (!v[8+i]) ix = i;
                dc = tbl(v[7:0]);
                mdig[ix] = dc[3:0];
                merr[ix] = dc[4];
                mseen[ix] = 1'b1;
                if (&mseen) begin e_fr = 1'b1; mseen = '0; end
            end
        end
        for (int i = 0; i < D; i++) e_dig[4*i +: 4] = mdig[i];
        check("upd", 64'(upd), 64'(e_upd));
        check("frame_done", 64'(frame_done), 64'(e_fr));
        check("digits", 64'(digits), 64'(e_dig));
        check("digit_err", 64'(digit_err), 64'(merr));
        if (e_upd) begin
            check("upd_idx", 64'(upd_idx), 64'(ix));
            check("upd_code", 64'(upd_code), 64'(dc[3:0]));
        end
        if (upd) begin
            upd_cnt++; last_upd_cyc = n; last_idx = int'(upd_idx); last_code = int'(upd_code);
        end
        if (frame_done) begin frame_cnt++; frame_cyc = n; end
    end

    // -------------------------------------------------- stimulus
    int ac;

    task automatic step(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] a, input logic [7:0] s);
        an = a; seg = s; ac = cyc;
    endtask

    localparam logic [7:0] PAT [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'hC1, 8'h1F};

    initial begin
        int u0, f0;
        logic [7:0] a;
        @(negedge clk); #1;
        step(3);
        rst = 1'b0;
        step(5);
        check("reset digits", 64'(digits), 64'h0000_0000_FFFF_FFFF);
        check("reset digit_err", 64'(digit_err), 64'h0);
        check("reset no upd", 64'(upd_cnt), 64'd0);
        check("reset no frame", 64'(frame_cnt), 64'd0);

        // single capture, latency
        u0 = upd_cnt;
        apply(8'hFB, 8'h0D);
        step(10);
        check("single upd count", 64'(upd_cnt - u0), 64'd1);
        check("single latency", 64'(last_upd_cyc - ac), 64'd6);
        check("single idx", 64'(last_idx), 64'd2);
        check("single code", 64'(last_code), 64'd3);
        check("single digit2", 64'(digits[11:8]), 64'h3);

        // glitch shorter than STABLE_CYCLES
        u0 = upd_cnt;
        apply(8'hFE, 8'h03);
        step(3);
        apply(8'hFE, 8'h9F);
        step(10);
        check("glitch upd count", 64'(upd_cnt - u0), 64'd1);
        check("glitch idx", 64'(last_idx), 64'd0);
        check("glitch code", 64'(last_code), 64'd1);
        check("glitch digit0", 64'(digits[3:0]), 64'h1);

        // invalid then dot on digit 5
        apply(8'hDF, 8'hAA);
        step(10);
        check("invalid code", 64'(last_code), 64'hE);
        check("invalid err5", 64'(digit_err[5]), 64'd1);
        check("invalid digit5", 64'(digits[23:20]), 64'hE);
        apply(8'hDF, 8'hFE);
        step(10);
        check("dot code", 64'(last_code), 64'hA);
        check("dot err5", 64'(digit_err[5]), 64'd0);

        // two full scans
        for (int r = 0; r < 2; r++) begin
            u0 = upd_cnt; f0 = frame_cnt;
            for (int i = 0; i < D; i++) begin
                a = 8'hFF; a[i] = 1'b0;
                apply(a, PAT[i]);
                step(8);
            end
            step(4);
            check("scan upd count", 64'(upd_cnt - u0), 64'd8);
            check("scan frame count", 64'(frame_cnt - f0), 64'd1);
            check("scan frame with 8th", 64'(frame_cyc), 64'(last_upd_cyc));
            check("scan last idx", 64'(last_idx), 64'd7);
            check("scan digits", 64'(digits), 64'h0000_0000_7654_3210);
        end

        // non-one-hot anode
        u0 = upd_cnt;
        apply(8'hFC, 8'h01);
        step(10);
        check("nonhot no upd", 64'(upd_cnt - u0), 64'd0);

        // reset in the middle of a settle
        apply(8'hFF, 8'hFF);
        step(4);
        u0 = upd_cnt; f0 = frame_cnt;
        apply(8'hF7, 8'h99);
        step(4);
        rst = 1'b1; an = 8'hFF; seg = 8'hFF;
        step(3);
        rst = 1'b0;
        step(8);
        check("midrst no upd", 64'(upd_cnt - u0), 64'd0);
        check("midrst no frame", 64'(frame_cnt - f0), 64'd0);
        check("midrst digits", 64'(digits), 64'h0000_0000_FFFF_FFFF);
        check("midrst digit_err", 64'(digit_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
